// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input in clk cycles, one strobed result per period.
// Optional deglitch filter on the synchronized level when PWM_CAPTURE_FILTER_EN is defined.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic             i_pwm,
  output logic [CNT_W-1:0] o_period_cnt,
  output logic [CNT_W-1:0] o_high_cnt,
  output logic             o_valid,
  output logic             o_overflow,
  output logic             o_stuck_high,
  output logic             o_stuck_low
);

  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEASURE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   lvl;
  logic                   lvl_prev;
  logic                   rise;
  logic [CNT_W-1:0]       period_cnt;
  logic [CNT_W-1:0]       high_cnt;
  logic                   ovf;
  logic [TMO_W-1:0]       tmo_cnt;

  always_ff @(posedge clk) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], i_pwm};
  end

  assign s = sync[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
  // Level follows s only once the last three samples agree; shorter pulses never reach the counters.
  logic [1:0] s_hist;
  logic       filt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s_hist <= '0;
      filt   <= 1'b0;
    end else begin
      s_hist <= {s_hist[0], s};
      filt   <= lvl;
    end
  end

  assign lvl = (s == s_hist[0] && s == s_hist[1]) ? s : filt;
`else
  assign lvl = s;
`endif

  assign rise = lvl & ~lvl_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      lvl_prev     <= 1'b0;
      period_cnt   <= '0;
      high_cnt     <= '0;
      ovf          <= 1'b0;
      tmo_cnt      <= '0;
      o_period_cnt <= '0;
      o_high_cnt   <= '0;
      o_valid      <= 1'b0;
      o_overflow   <= 1'b0;
      o_stuck_high <= 1'b0;
      o_stuck_low  <= 1'b0;
    end else begin
      lvl_prev <= lvl;
      o_valid  <= 1'b0;
      if (!i_enable) begin
        state        <= IDLE;
        ovf          <= 1'b0;
        tmo_cnt      <= '0;
        o_stuck_high <= 1'b0;
        o_stuck_low  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state   <= WAIT_RISE;
            tmo_cnt <= '0;
          end
          WAIT_RISE, MEASURE: begin
            if (rise) begin
              // Only a rise that closes a tracked period publishes; the first one merely arms.
              if (state == MEASURE) begin
                o_period_cnt <= period_cnt;
                o_high_cnt   <= high_cnt;
                o_overflow   <= ovf;
                o_valid      <= 1'b1;
              end
              state        <= MEASURE;
              period_cnt   <= CNT_ONE;
              high_cnt     <= CNT_ONE;
              ovf          <= 1'b0;
              tmo_cnt      <= '0;
              o_stuck_high <= 1'b0;
              o_stuck_low  <= 1'b0;
            end else begin
              if (state == MEASURE) begin
                if (period_cnt == CNT_MAX) ovf <= 1'b1;
                else                       period_cnt <= period_cnt + CNT_ONE;
                if (lvl) begin
                  if (high_cnt == CNT_MAX) ovf <= 1'b1;
                  else                     high_cnt <= high_cnt + CNT_ONE;
                end
              end
              // Timer parks at the limit so the flags are raised once and then held.
              if (tmo_cnt != TMO_LIM) tmo_cnt <= tmo_cnt + TMO_W'(1);
              if (tmo_cnt == TMO_LAST) begin
                o_stuck_high <= lvl;
                o_stuck_low  <= ~lvl;
                state        <= WAIT_RISE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized bench for pwm_capture: a 16-bit and a 4-bit instance share one stimulus stream,
// each scored against a rise-to-rise reference model of the waveform.
module tb_pwm_capture;

  localparam int TMO = 1024;

  logic        clk;
  logic        reset;
  logic        i_enable;
  logic        i_pwm;

  logic [15:0] period16, high16;
  logic        valid16, ovf16, sth16, stl16;
  logic [3:0]  period4, high4;
  logic        valid4, ovf4, sth4, stl4;

  pwm_capture #(.CNT_W(16), .TIMEOUT(TMO), .SYNC_STAGES(2)) u_dut16 (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_pwm(i_pwm),
    .o_period_cnt(period16), .o_high_cnt(high16), .o_valid(valid16),
    .o_overflow(ovf16), .o_stuck_high(sth16), .o_stuck_low(stl16)
  );

  pwm_capture #(.CNT_W(4), .TIMEOUT(TMO), .SYNC_STAGES(2)) u_dut4 (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_pwm(i_pwm),
    .o_period_cnt(period4), .o_high_cnt(high4), .o_valid(valid4),
    .o_overflow(ovf4), .o_stuck_high(sth4), .o_stuck_low(stl4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: works on the driven sample stream; a result is the distance between
  // consecutive tracked rises and the number of high samples in that span, saturated per width.
  typedef struct {
    int period;
    int high;
    int ovf;
  } res_t;

  res_t exp_q16[$];
  res_t exp_q4[$];

  int k         = 0;
  int last_rise = 0;
  int hi_cnt    = 0;
  bit rise_ok   = 1'b0;
  bit prev_lvl  = 1'b0;
  bit flt       = 1'b0;
  bit h1        = 1'b0;
  bit h2        = 1'b0;

  function automatic res_t sat(input int p, input int h, input int mx);
    res_t r;
    r.period = (p > mx) ? mx : p;
    r.high   = (h > mx) ? mx : h;
    r.ovf    = (p > mx) ? 1 : 0;
    return r;
  endfunction

  task automatic step(input bit pwm, input bit en, input bit rst);
    bit lvl;
    i_pwm    = pwm;
    i_enable = en;
    reset    = rst;
    if (rst) begin
      flt = 1'b0; h1 = 1'b0; h2 = 1'b0; prev_lvl = 1'b0; rise_ok = 1'b0;
    end else begin
`ifdef PWM_CAPTURE_FILTER_EN
      if (pwm == h1 && pwm == h2) flt = pwm;
      lvl = flt;
      h2  = h1;
      h1  = pwm;
`else
      lvl = pwm;
`endif
      if (!en) begin
        rise_ok = 1'b0;
      end else if (lvl && !prev_lvl) begin
        if (rise_ok && (k - last_rise) <= TMO) begin
          exp_q16.push_back(sat(k - last_rise, hi_cnt, 65535));
          exp_q4.push_back(sat(k - last_rise, hi_cnt, 15));
        end
        rise_ok   = 1'b1;
        last_rise = k;
        hi_cnt    = 0;
      end
      if (lvl) hi_cnt++;
      prev_lvl = lvl;
    end
    k++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_periods(input int p, input int h, input int n);
    for (int j = 0; j < n; j++)
      for (int i = 0; i < p; i++)
        step(i < h, 1'b1, 1'b0);
  endtask

  task automatic check_stuck(input string tag, input int exp_hi, input int exp_lo);
    check({tag, "_hi16"}, int'(sth16), exp_hi);
    check({tag, "_lo16"}, int'(stl16), exp_lo);
    check({tag, "_hi4"},  int'(sth4),  exp_hi);
    check({tag, "_lo4"},  int'(stl4),  exp_lo);
  endtask

  always @(negedge clk) begin
    res_t r;
    if (valid16) begin
      if (exp_q16.size() == 0) check("extra_valid16", 1, 0);
      else begin
        r = exp_q16.pop_front();
        check("period16", int'(period16), r.period);
        check("high16",   int'(high16),   r.high);
        check("ovf16",    int'(ovf16),    r.ovf);
      end
    end
    if (valid4) begin
      if (exp_q4.size() == 0) check("extra_valid4", 1, 0);
      else begin
        r = exp_q4.pop_front();
        check("period4", int'(period4), r.period);
        check("high4",   int'(high4),   r.high);
        check("ovf4",    int'(ovf4),    r.ovf);
      end
    end
  end

  initial begin
    int p, h, n;
    i_pwm = 1'b0; i_enable = 1'b0; reset = 1'b1;
    repeat (4) step(1'b0, 1'b0, 1'b1);
    check("rst_period16", int'(period16), 0);
    check("rst_high16",   int'(high16),   0);
    check("rst_valid16",  int'(valid16),  0);
    check("rst_ovf16",    int'(ovf16),    0);
    check("rst_period4",  int'(period4),  0);
    check("rst_high4",    int'(high4),    0);
    check("rst_valid4",   int'(valid4),   0);
    check("rst_ovf4",     int'(ovf4),     0);
    check_stuck("rst", 0, 0);

    repeat (5) step(1'b0, 1'b1, 1'b0);
    run_periods(10, 5, 6);
    run_periods(10, 9, 4);
    run_periods(10, 1, 4);
    run_periods(10, 5, 3);
    run_periods(20, 10, 3);
    run_periods(20, 18, 2);
    run_periods(10, 5, 2);

    for (int ph = 0; ph < 8; ph++) begin
      p = int'($urandom_range(40, 4));
      h = int'($urandom_range(p - 1, 1));
      n = int'($urandom_range(5, 2));
      run_periods(p, h, n);
    end

    // Line held high long past the timeout, then resumes.
    run_periods(10, 5, 2);
    for (int i = 0; i < 1100; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (i == 990) check_stuck("pre_tmo_high", 0, 0);
    end
    check_stuck("stuck_high", 1, 0);
    repeat (5) step(1'b0, 1'b1, 1'b0);
    run_periods(10, 5, 4);
    check_stuck("resume_high", 0, 0);

    // Line held low long past the timeout, then resumes.
    run_periods(10, 5, 2);
    for (int i = 0; i < 1100; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (i == 990) check_stuck("pre_tmo_low", 0, 0);
    end
    check_stuck("stuck_low", 0, 1);
    run_periods(10, 5, 4);
    check_stuck("resume_low", 0, 0);

    // Enable dropped for three cycles in the low phase.
    run_periods(10, 5, 3);
    for (int i = 0; i < 10; i++) step(i < 5, !(i >= 6 && i <= 8), 1'b0);
    run_periods(10, 5, 3);

    // One-cycle reset in the low phase.
    for (int i = 0; i < 10; i++) step(i < 5, 1'b1, i == 6);
    run_periods(10, 5, 3);

    // One-cycle low glitch inside the high phase.
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 10; i++) step(i < 5 && i != 2, 1'b1, 1'b0);
    run_periods(10, 5, 3);

    repeat (20) step(1'b0, 1'b1, 1'b0);
    check("pending16", exp_q16.size(), 0);
    check("pending4",  exp_q4.size(),  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
